// File: rtl/da_decim_buffer.sv
// da_decim_buffer
//   Output stage behind the parallel distributed-arithmetic FIR. Drops the
//   filter's warm-up samples, integrates and dumps groups of R samples
//   (decimation by R), and queues the decimated sums in a show-ahead FIFO
//   with a valid/ready handshake toward the consumer.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous reset, active low
//   en_in     y_in carries a valid filter sample this cycle
//   y_in      signed filter sample, W_IN bits
//   m_data    signed decimated sum at the FIFO head, W_ACC bits
//   m_valid   FIFO non-empty, m_data valid
//   m_ready   consumer accepts m_data this cycle
//   level     FIFO occupancy, 0..DEPTH
//   warm      warm-up complete, samples are being integrated
//   overflow  sticky: a decimated sum was dropped on a full FIFO
module da_decim_buffer #(
  parameter int W_IN  = 7,
  parameter int R     = 4,
  parameter int DEPTH = 4,
  parameter int SKIP  = 5,
  localparam int W_ACC = W_IN + $clog2(R),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_in,
  input  logic signed [W_IN-1:0]  y_in,
  output logic signed [W_ACC-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LVL_W-1:0]        level,
  output logic                    warm,
  output logic                    overflow
);

  localparam int PH_W  = $clog2(R);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  // Full-precision sign extension; the accumulator range cannot overflow.
  function automatic logic signed [W_ACC-1:0] sext(input logic signed [W_IN-1:0] x);
    return W_ACC'(x);
  endfunction

  logic [CNT_W-1:0]        wcnt;
  logic [PH_W-1:0]         phase;
  logic signed [W_ACC-1:0] acc_p0;
  logic signed [W_ACC-1:0] data_p0;
  logic                    vld_p0;
  logic signed [W_ACC-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    full;
  logic                    pop;
  logic                    push;

  // Warm-up counter saturates at SKIP; reaching it is what "warm" means.
  assign warm    = (wcnt == CNT_W'(SKIP));
  assign m_valid = (level != '0);
  assign m_data  = mem[rd_ptr];

  always_comb begin
    data_p0 = acc_p0 + sext(y_in);
    vld_p0  = warm && en_in && (phase == PH_W'(R - 1));
    full    = (level == LVL_W'(DEPTH));
    pop     = m_valid && m_ready;
    // A pop on a full FIFO frees the slot the dump writes into.
    push    = vld_p0 && (!full || pop);
  end

  // Stage p0: warm-up, integrate and dump
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt   <= '0;
      phase  <= '0;
      acc_p0 <= '0;
    end else if (en_in) begin
      if (!warm) begin
        wcnt <= wcnt + 1'b1;
      end else if (vld_p0) begin
        phase  <= '0;
        acc_p0 <= '0;
      end else begin
        phase  <= phase + 1'b1;
        acc_p0 <= data_p0;
      end
    end
  end

  // Stage p1: FIFO storage and control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= data_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (vld_p0 && full && !pop) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
